// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: assembles two received UART bytes into a 16-bit command
// {high byte, low byte} and passes a response byte straight through to the
// UART transmitter. Contains the team UART (Uart) as a sub-module.
// Optional feature: define UART_CMD_RX_TIMEOUT_EN to abandon a half-received
// command after TO_CYC idle clk cycles in the LOW state.

module Uart #(
    parameter int BAUD_CYC = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       clr_rx_rdy_i,
    output logic [7:0] rx_data_o,
    output logic       rx_rdy_o,
    input  logic [7:0] tx_data_i,
    input  logic       trmt_i,
    output logic       tx_o,
    output logic       tx_done_o
);

    localparam int BW = $clog2(BAUD_CYC + 1);

    logic          rx_sync1_q, rx_sync2_q;
    logic          rx_busy_q;
    logic [BW-1:0] rx_baud_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_rdy_q;
    logic          rx_start, rx_sample, rx_done;

    logic          tx_busy_q;
    logic [BW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_shift_q;
    logic          tx_done_q;

    assign rx_start  = !rx_busy_q && !rx_sync2_q;
    assign rx_sample = rx_busy_q && (rx_baud_q == '0);
    assign rx_done   = rx_sample && (rx_bit_q == 4'd9);

    // Double-flop the asynchronous RX line; idles high so reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= rx_i;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    // Receiver: first sample lands mid start bit, then one sample per bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy_q  <= 1'b0;
            rx_baud_q  <= '0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 8'h00;
        end else if (rx_start) begin
            rx_busy_q <= 1'b1;
            rx_baud_q <= BW'(BAUD_CYC / 2);
            rx_bit_q  <= 4'd0;
        end else if (rx_sample) begin
            rx_baud_q <= BW'(BAUD_CYC - 1);
            rx_bit_q  <= rx_bit_q + 4'd1;
            if (rx_bit_q >= 4'd1 && rx_bit_q <= 4'd8) begin
                rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
            end
            if (rx_done) begin
                rx_busy_q <= 1'b0;
            end
        end else if (rx_busy_q) begin
            rx_baud_q <= rx_baud_q - BW'(1);
        end
    end

    // Byte-ready flag: set at the stop-bit sample, cleared by consumer or a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_q <= 1'b0;
        end else if (rx_done) begin
            rx_rdy_q <= 1'b1;
        end else if (clr_rx_rdy_i || rx_start) begin
            rx_rdy_q <= 1'b0;
        end
    end

    // Transmitter: shifts {stop, data, start} out LSB first, one bit per period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_baud_q  <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= 10'h3FF;
            tx_done_q  <= 1'b0;
        end else if (trmt_i) begin
            tx_busy_q  <= 1'b1;
            tx_baud_q  <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= {1'b1, tx_data_i, 1'b0};
            tx_done_q  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BW'(BAUD_CYC - 1)) begin
                tx_baud_q  <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + BW'(1);
            end
        end
    end

    assign rx_data_o = rx_shift_q;
    assign rx_rdy_o  = rx_rdy_q;
    assign tx_o      = tx_shift_q[0];
    assign tx_done_o = tx_done_q;

endmodule

module uart_cmd_rx #(
    parameter int TO_CYC   = 1_000_000,
    parameter int BAUD_CYC = 5208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    typedef enum logic {
        HIGH = 1'b0,
        LOW  = 1'b1
    } state_t;

    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;

    state_t      state_q, state_d;
    logic [7:0]  high_q, high_d;
    logic [15:0] cmd_q, cmd_d;
    logic        rdy_q, rdy_d;

`ifdef UART_CMD_RX_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    Uart #(
        .BAUD_CYC(BAUD_CYC)
    ) u_uart (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (RX),
        .clr_rx_rdy_i(clr_rx_rdy),
        .rx_data_o   (rx_data),
        .rx_rdy_o    (rx_rdy),
        .tx_data_i   (resp),
        .trmt_i      (trmt),
        .tx_o        (TX),
        .tx_done_o   (tx_done)
    );

    // Assembler state, captured high byte and the published command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HIGH;
            high_q  <= 8'h00;
            cmd_q   <= 16'h0000;
            rdy_q   <= 1'b0;
`ifdef UART_CMD_RX_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
`ifdef UART_CMD_RX_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    // Next state: consume each byte immediately; setting cmd_rdy beats a same-cycle clear
    always_comb begin
        state_d    = state_q;
        high_d     = high_q;
        cmd_d      = cmd_q;
        rdy_d      = rdy_q;
        clr_rx_rdy = 1'b0;
`ifdef UART_CMD_RX_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        if (clr_cmd_rdy) begin
            rdy_d = 1'b0;
        end
        case (state_q)
            HIGH: begin
                if (rx_rdy) begin
                    high_d     = rx_data;
                    clr_rx_rdy = 1'b1;
                    rdy_d      = 1'b0;
                    state_d    = LOW;
`ifdef UART_CMD_RX_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            LOW: begin
                if (rx_rdy) begin
                    cmd_d      = {high_q, rx_data};
                    clr_rx_rdy = 1'b1;
                    rdy_d      = 1'b1;
                    state_d    = HIGH;
`ifdef UART_CMD_RX_TIMEOUT_EN
                    to_cnt_d   = '0;
                end else if (to_cnt_q == TW'(TO_CYC - 1)) begin
                    state_d    = HIGH;
                    high_d     = 8'h00;
                    to_cnt_d   = '0;
                end else begin
                    to_cnt_d   = to_cnt_q + TW'(1);
`endif
                end
            end
            default: begin
                state_d = HIGH;
            end
        endcase
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed testbench for uart_cmd_rx: serial bytes are driven on RX with a
// short bit period and the assembled command, ready flag and TX frame are
// compared against hand-computed values.

module tb_uart_cmd_rx;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    int compared = 0;
    int mismatched = 0;

    uart_cmd_rx #(
        .TO_CYC  (1000),
        .BAUD_CYC(BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .trmt       (trmt),
        .tx_done    (tx_done)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Hard stop in case anything stalls
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        RX = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(BAUD);
        end
        RX = 1'b1;
        tick(BAUD);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        compared++; if (cmd !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_cmd: got %h expected 0000", cmd); end
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rdy: got %b expected 0", cmd_rdy); end
        compared++; if (TX !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_tx: got %b expected 1", TX); end
        compared++; if (tx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_txdone: got %b expected 0", tx_done); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        sendByte(8'hA5);
        tick(2);
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_rdy_after_high: got %b expected 0", cmd_rdy); end
        compared++; if (cmd !== 16'h0000) begin mismatched++; $display("[TB] FAIL basic_cmd_after_high: got %h expected 0000", cmd); end
        sendByte(8'h3C);
        tick(2);
        compared++; if (cmd !== 16'hA53C) begin mismatched++; $display("[TB] FAIL basic_cmd: got %h expected a53c", cmd); end
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_rdy: got %b expected 1", cmd_rdy); end
    endtask

    task automatic test_back_to_back();
        sendByte(8'h12);
        tick(2);
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_rdy_fall: got %b expected 0", cmd_rdy); end
        compared++; if (cmd !== 16'hA53C) begin mismatched++; $display("[TB] FAIL b2b_cmd_hold: got %h expected a53c", cmd); end
        sendByte(8'h34);
        tick(2);
        compared++; if (cmd !== 16'h1234) begin mismatched++; $display("[TB] FAIL b2b_cmd: got %h expected 1234", cmd); end
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_rdy: got %b expected 1", cmd_rdy); end
    endtask

    task automatic test_clr();
        tick(5);
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL clr_rdy_holds: got %b expected 1", cmd_rdy); end
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_rdy: got %b expected 0", cmd_rdy); end
        compared++; if (cmd !== 16'h1234) begin mismatched++; $display("[TB] FAIL clr_cmd_kept: got %h expected 1234", cmd); end
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        tick(2);
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_when_low: got %b expected 0", cmd_rdy); end
    endtask

    task automatic test_set_wins();
        logic seen;
        seen = 1'b0;
        sendByte(8'h55);
        tick(2);
        clr_cmd_rdy = 1'b1;
        fork
            sendByte(8'hAA);
            begin
                for (int i = 0; i < 12 * BAUD; i++) begin
                    tick(1);
                    if (cmd_rdy === 1'b1) begin
                        clr_cmd_rdy = 1'b0;
                        seen = 1'b1;
                        break;
                    end
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        tick(3);
        compared++; if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL setwins_seen: got %b expected 1 (rdy never rose under clr)", seen); end
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL setwins_rdy: got %b expected 1", cmd_rdy); end
        compared++; if (cmd !== 16'h55AA) begin mismatched++; $display("[TB] FAIL setwins_cmd: got %h expected 55aa", cmd); end
    endtask

    task automatic test_tx();
        logic [9:0] expFrame;
        expFrame = 10'b1_1010_0101_0;
        resp = 8'hA5;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        compared++; if (tx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL tx_done_start: got %b expected 0", tx_done); end
        fork
            begin
                tick(BAUD / 2);
                for (int i = 0; i < 10; i++) begin
                    compared++; if (TX !== expFrame[i]) begin mismatched++; $display("[TB] FAIL tx_bit%0d: got %b expected %b", i, TX, expFrame[i]); end
                    if (i < 9) tick(BAUD);
                end
                compared++; if (tx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL tx_done_mid_stop: got %b expected 0", tx_done); end
                tick(BAUD);
                compared++; if (tx_done !== 1'b1) begin mismatched++; $display("[TB] FAIL tx_done_end: got %b expected 1", tx_done); end
                compared++; if (TX !== 1'b1) begin mismatched++; $display("[TB] FAIL tx_idle_end: got %b expected 1", TX); end
            end
            begin
                tick(4);
                sendByte(8'h0F);
                sendByte(8'hF0);
            end
        join
        tick(2);
        compared++; if (cmd !== 16'h0FF0) begin mismatched++; $display("[TB] FAIL tx_concurrent_cmd: got %h expected 0ff0", cmd); end
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL tx_concurrent_rdy: got %b expected 1", cmd_rdy); end
    endtask

    task automatic test_reset_partial();
        sendByte(8'hFF);
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        compared++; if (cmd !== 16'h0000) begin mismatched++; $display("[TB] FAIL rstp_cmd: got %h expected 0000", cmd); end
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstp_rdy: got %b expected 0", cmd_rdy); end
        compared++; if (TX !== 1'b1) begin mismatched++; $display("[TB] FAIL rstp_tx: got %b expected 1", TX); end
        compared++; if (tx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstp_txdone: got %b expected 0", tx_done); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sendByte(8'h00);
        sendByte(8'h01);
        tick(2);
        compared++; if (cmd !== 16'h0001) begin mismatched++; $display("[TB] FAIL rstp_new_cmd: got %h expected 0001", cmd); end
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL rstp_new_rdy: got %b expected 1", cmd_rdy); end
    endtask

    task automatic test_timeout();
        sendByte(8'hDE);
        tick(1100);
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL to_rdy_idle: got %b expected 0", cmd_rdy); end
        compared++; if (cmd !== 16'h0001) begin mismatched++; $display("[TB] FAIL to_cmd_idle: got %h expected 0001", cmd); end
        sendByte(8'hAD);
        tick(2);
`ifdef UART_CMD_RX_TIMEOUT_EN
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL to_rdy_ad: got %b expected 0", cmd_rdy); end
        compared++; if (cmd !== 16'h0001) begin mismatched++; $display("[TB] FAIL to_cmd_ad: got %h expected 0001", cmd); end
`else
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL to_rdy_ad: got %b expected 1", cmd_rdy); end
        compared++; if (cmd !== 16'hDEAD) begin mismatched++; $display("[TB] FAIL to_cmd_ad: got %h expected dead", cmd); end
`endif
        sendByte(8'hBE);
        tick(2);
`ifdef UART_CMD_RX_TIMEOUT_EN
        compared++; if (cmd !== 16'hADBE) begin mismatched++; $display("[TB] FAIL to_cmd_be: got %h expected adbe", cmd); end
        compared++; if (cmd_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL to_rdy_be: got %b expected 1", cmd_rdy); end
`else
        compared++; if (cmd !== 16'hDEAD) begin mismatched++; $display("[TB] FAIL to_cmd_be: got %h expected dead", cmd); end
        compared++; if (cmd_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL to_rdy_be: got %b expected 0", cmd_rdy); end
`endif
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] starting uart_cmd_rx bench");
        test_reset();
        test_basic();
        test_back_to_back();
        test_clr();
        test_set_wins();
        test_tx();
        test_reset_partial();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
